uart_bus_responder: RTL and testbench
=====================================

Name: uart_bus_responder

Overview:
- Device-side responder for the CPU's parallel UART handshake (rdn/wrn strobes; tbre/tsre/data_ready status).
- The CPU top is the initiator. This block sits on the shared low data byte and converts bus writes into an 8N1 serial stream on txd.
- It also deserialises rxd into a one-byte receive buffer that the CPU reads with rdn.
- Used as the board UART replacement and as the bench model for CPU UART tests.

Parameters:
- CLK_HZ, 50000000, clk_50MHz frequency in Hz.
- BAUD, 115200, serial bit rate.
- BAUD_DIV, CLK_HZ/BAUD (integer truncation, 434 at defaults), clock cycles per serial bit; must be >= 4.

Ports:
- clk_50MHz  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- bus_data  inout  16  shared data bus; only [7:0] carries payload.
- rdn  input  1  read strobe, active low.
- wrn  input  1  write strobe, active low; the byte is committed on its rising edge.
- tbre  output  1  transmit holding register empty; CPU may write.
- tsre  output  1  transmit shift register idle.
- data_ready  output  1  receive buffer holds an unread byte.
- txd  output  1  serial out, idle high.
- rxd  input  1  serial in, idle high.

Behaviour:
- Reset (rst=0, async), all outputs forced immediately:
  - txd=1, tbre=1, tsre=1, data_ready=0, bus_data hi-Z.
  - Both state machines go to IDLE; counters, buffers and sync flops clear; synced rdn/wrn/rxd history resets to 1.
  - Reset mid-frame aborts the frame. txd returns to 1 within the reset assertion.
- Synchronisers: rdn, wrn and rxd each pass through a 2-flop synchroniser (rdn_s, wrn_s, rxd_s).
- Read port:
  - bus_data = {8'h00, rx_buf} whenever the raw rdn=0 and rst=1. This path is combinational, with no clock latency. Otherwise bus_data is hi-Z.
  - A rising edge of rdn_s clears data_ready, unless a byte was loaded into rx_buf since the falling edge of rdn_s. In that case data_ready stays 1.
- Write port:
  - bus_data[7:0] is sampled every cycle while wrn_s=0.
  - On a rising edge of wrn_s with tbre=1, the last sample loads tx_hold and tbre goes to 0 in the next cycle.
  - A rising edge of wrn_s with tbre=0 is ignored; tx_hold is unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if tx_hold is full, move tx_hold into the shifter, set tbre=1 and tsre=0 in the same cycle, and go to START.
  - START: txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each; a bit index counts 0..7.
  - STOP: txd=1 for BAUD_DIV cycles, then IDLE. tsre=1 on entry to IDLE unless tx_hold is full; in that case the next frame starts with no idle gap.
  - Frame length: exactly 10*BAUD_DIV cycles.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a 1->0 transition of rxd_s moves to START.
  - START: wait BAUD_DIV/2 cycles. If rxd_s=1 at that point it is a false start: return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at BAUD_DIV spacing, LSB first.
  - STOP: sample after BAUD_DIV cycles.
    - stop=1: rx_buf<=byte and data_ready<=1; this overwrites an unread byte, latest wins.
    - stop=0 (framing error): discard the byte; rx_buf and data_ready are unchanged.
  - Return to IDLE after the stop sample; the next start edge is accepted immediately.
- Simultaneous events:
  - An rx load and an rdn_s rising edge in the same cycle: the load wins, data_ready=1.
  - A wrn commit and a TX IDLE->START transfer in the same cycle: the transfer uses the old tx_hold, and the new byte lands in tx_hold (tbre=0).
  - TX and RX are fully independent.

Optional Feature:
- UART_LOOPBACK_EN defined:
  - The RX synchroniser input is the internal TX serial line, not rxd.
  - txd is held at 1.
  - rxd is ignored.
- UART_LOOPBACK_EN undefined: normal external operation as above.

Test Plan:
- Reset check: assert rst=0 mid-TX-frame -> txd=1, tbre=1, tsre=1, data_ready=0 and bus_data hi-Z immediately; no residual frame after release.
- TX framing: BAUD_DIV=16; write 0x55 (wrn low 2 cycles) ->
  - tbre=0 for 1 cycle, then 1;
  - txd = 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit;
  - tsre=1 exactly 160 cycles after the frame starts.
- Back-to-back writes: write 0xA3 during frame 1, then 0x7E while tbre=0 ->
  - second frame carries 0xA3 with no gap;
  - 0x7E is dropped;
  - tsre stays 0 across 320 cycles.
- RX and read: drive rxd with an 8N1 frame of 0x3C at BAUD_DIV=16 ->
  - data_ready=1 about 9.5 bit times plus 2 cycles after the start edge;
  - rdn=0 -> bus_data=16'h003C combinationally;
  - rdn rise -> data_ready=0 two to three cycles later.
- RX errors:
  - rxd low for 3 cycles -> no reception.
  - A frame with stop=0 -> data_ready stays 0 and rx_buf is unchanged.
  - A second valid byte 0x81 arriving before a read -> bus reads 0x0081.
- Loopback (UART_LOOPBACK_EN): write 0xC6 -> txd stays 1 and data_ready=1 after 10 bit times; the read returns 0x00C6.

Source files
------------

// File: rtl/uart_bus_responder.sv
// Device-side UART for the CPU's rdn/wrn handshake: bus writes become 8N1 frames on txd,
// rxd frames land in a one-byte buffer. Define UART_LOOPBACK_EN to feed TX back into RX.
module uart_bus_responder #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned BAUD_DIV = CLK_HZ / BAUD
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  inout  wire  [15:0] bus_data,
  input  logic        rdn,
  input  logic        wrn,
  output logic        tbre,
  output logic        tsre,
  output logic        data_ready,
  output logic        txd,
  input  logic        rxd
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic rdn_m_q, rdn_s_q, rdn_h_q;
  logic wrn_m_q, wrn_s_q, wrn_h_q;
  logic rxd_m_q, rxd_s_q, rxd_h_q;
  logic rx_src;

  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       tx_hold_q, tx_hold_d;
  logic [7:0]       wr_sample_q, wr_sample_d;
  logic             tx_line_q, tx_line_d;
  logic             tbre_q, tbre_d;
  logic             tsre_q, tsre_d;
  logic             tx_take;

  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_buf_q, rx_buf_d;
  logic             dr_q, dr_d;
  logic             rd_loaded_q, rd_loaded_d;
  logic             rx_load;

  logic rdn_rise, rdn_fall, wrn_rise;
  logic [7:0] unused_bus_hi;

  assign rdn_rise = rdn_s_q & ~rdn_h_q;
  assign rdn_fall = ~rdn_s_q & rdn_h_q;
  assign wrn_rise = wrn_s_q & ~wrn_h_q;
  assign unused_bus_hi = bus_data[15:8];

  // Read data is driven straight off the raw strobe, no clock latency
  assign bus_data = (!rdn && rst) ? {8'h00, rx_buf_q} : 16'hzzzz;

  assign tbre       = tbre_q;
  assign tsre       = tsre_q;
  assign data_ready = dr_q;

`ifdef UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_src     = tx_line_q;
  assign txd        = 1'b1;
`else
  assign rx_src = rxd;
  assign txd    = tx_line_q;
`endif

  // TX frame sequencer; a full holding register is taken from IDLE or straight out of STOP
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tsre_d     = tsre_q;
    tx_take    = 1'b0;
    case (tx_state_q)
      S_IDLE: tx_take = ~tbre_q;
      S_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            tx_take = 1'b1;
          end else begin
            tx_state_d = S_IDLE;
            tsre_d     = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_take) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_hold_q;
      tx_line_d  = 1'b0;
      tsre_d     = 1'b0;
    end
  end

  // Write port: a commit racing a transfer lands in the register the transfer just emptied
  always_comb begin
    wr_sample_d = wr_sample_q;
    tx_hold_d   = tx_hold_q;
    tbre_d      = tbre_q;
    if (!wrn_s_q) wr_sample_d = bus_data[7:0];
    if (tx_take) tbre_d = 1'b1;
    if (wrn_rise && (tbre_q || tx_take)) begin
      tx_hold_d = wr_sample_q;
      tbre_d    = 1'b0;
    end
  end

  // RX frame sequencer, sampling mid-bit from the start edge
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_h_q && !rxd_s_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_load    = rxd_s_q;
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A byte arriving during a read keeps data_ready set past the end of that read
  always_comb begin
    rx_buf_d    = rx_load ? rx_shift_q : rx_buf_q;
    rd_loaded_d = rd_loaded_q;
    dr_d        = dr_q;
    if (rx_load)       rd_loaded_d = 1'b1;
    else if (rdn_fall) rd_loaded_d = 1'b0;
    if (rx_load)                      dr_d = 1'b1;
    else if (rdn_rise && !rd_loaded_q) dr_d = 1'b0;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      {rdn_m_q, rdn_s_q, rdn_h_q} <= 3'b111;
      {wrn_m_q, wrn_s_q, wrn_h_q} <= 3'b111;
      {rxd_m_q, rxd_s_q, rxd_h_q} <= 3'b111;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      wr_sample_q <= 8'h00;
      tx_line_q   <= 1'b1;
      tbre_q      <= 1'b1;
      tsre_q      <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_buf_q    <= 8'h00;
      dr_q        <= 1'b0;
      rd_loaded_q <= 1'b0;
    end else begin
      {rdn_m_q, rdn_s_q, rdn_h_q} <= {rdn, rdn_m_q, rdn_s_q};
      {wrn_m_q, wrn_s_q, wrn_h_q} <= {wrn, wrn_m_q, wrn_s_q};
      {rxd_m_q, rxd_s_q, rxd_h_q} <= {rx_src, rxd_m_q, rxd_s_q};
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      wr_sample_q <= wr_sample_d;
      tx_line_q   <= tx_line_d;
      tbre_q      <= tbre_d;
      tsre_q      <= tsre_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_buf_q    <= rx_buf_d;
      dr_q        <= dr_d;
      rd_loaded_q <= rd_loaded_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder at BAUD_DIV=16; the UART_LOOPBACK_EN build runs the loopback test.
module tb_uart_bus_responder;

  localparam int unsigned DIV = 16;

  logic clk = 1'b0;
  logic rst, rdn, wrn, rxd;
  logic tbre, tsre, data_ready, txd;
  tri1 [15:0] bus_data;
  logic       drv_en;
  logic [7:0] drv_byte;

  int n_pass = 0;
  int n_chk  = 0;
  logic cap_txd  [0:399];
  logic cap_tsre [0:399];

  assign bus_data = drv_en ? {8'h00, drv_byte} : 16'hzzzz;
  always #5 clk = ~clk;

  uart_bus_responder #(.BAUD_DIV(DIV)) dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .bus_data  (bus_data),
    .rdn       (rdn),
    .wrn       (wrn),
    .tbre      (tbre),
    .tsre      (tsre),
    .data_ready(data_ready),
    .txd       (txd),
    .rxd       (rxd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Line level of bit slot b of an 8N1 frame (slot 0 start, 1..8 data LSB first, 9 stop, then idle)
  function automatic logic fbit(input logic [7:0] d, input logic stop, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return stop;
    return 1'b1;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1 drv_byte = b; drv_en = 1'b1; wrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 wrn = 1'b1;
    repeat (4) @(posedge clk);
    #1 drv_en = 1'b0;
  endtask

  task automatic capture(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (txd !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    if (txd !== 1'b0) begin
      n_chk++;
      $display("FAIL tx_start_timeout: txd=%b after %0d cycles, want 0", txd, k);
    end else begin
      for (int i = 0; i < n; i++) begin
        cap_txd[i]  = txd;
        cap_tsre[i] = tsre;
        @(negedge clk);
      end
    end
  endtask

  // Each bit slot checked at its first, middle and last cycle
  task automatic check_frame(input int base, input logic [7:0] d, input string tag);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("%s_b%0d_first", tag, j), 32'(cap_txd[base + j*DIV]), 32'(fbit(d, 1'b1, j)));
      chk($sformatf("%s_b%0d_mid", tag, j), 32'(cap_txd[base + j*DIV + DIV/2]), 32'(fbit(d, 1'b1, j)));
      chk($sformatf("%s_b%0d_last", tag, j), 32'(cap_txd[base + j*DIV + DIV-1]), 32'(fbit(d, 1'b1, j)));
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, output int rise);
    logic prev;
    rise = -1;
    prev = data_ready;
    for (int c = 0; c < 10*DIV + 32; c++) begin
      @(posedge clk); #1 rxd = fbit(d, stop, c / DIV);
      @(negedge clk);
      if (rise < 0 && data_ready && !prev) rise = c;
      prev = data_ready;
    end
  endtask

  task automatic send_glitch();
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic rd_check(input string name, input logic [15:0] exp_bus, input logic dr_before);
    @(posedge clk); #1 rdn = 1'b0;
    #1 chk({name, "_bus"}, 32'(bus_data), 32'(exp_bus));
    repeat (3) @(posedge clk);
    #1 rdn = 1'b1;
    repeat (3) @(negedge clk);
    chk({name, "_dr_hold"}, 32'(data_ready), 32'(dr_before));
    @(negedge clk);
    chk({name, "_dr_clr"}, 32'(data_ready), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        glitch;
    logic        do_read;
    logic        exp_dr;
    logic [15:0] exp_bus;
  } rx_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    rx_vec_t tbl [5];
    int rise, cnt;
    logic [7:0] rb, exp_buf;
    logic rstop, exp_dr;

    tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h003C};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h003C};
    tbl[2] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h003C};
    tbl[3] = '{8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0099};
    tbl[4] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0081};

    rst = 1'b1; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; drv_en = 1'b0; drv_byte = 8'h00;
    #2 rst = 1'b0; rdn = 1'b0;
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tbre", 32'(tbre), 32'd1);
    chk("rst_tsre", 32'(tsre), 32'd1);
    chk("rst_dr", 32'(data_ready), 32'd0);
    chk("rst_bus_z", 32'(bus_data), 32'hFFFF);
    rdn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);

`ifdef UART_LOOPBACK_EN
    write_byte(8'hC6);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) cnt++;
      if (i == 100) chk("lb_dr_early", 32'(data_ready), 32'd0);
    end
    chk("lb_txd_idle", 32'(cnt), 32'd0);
    chk("lb_dr", 32'(data_ready), 32'd1);
    rd_check("lb_read", 16'h00C6, 1'b1);
`else
    // Single frame of 0x55
    fork
      capture(170);
      write_byte(8'h55);
      begin : tbre_mon
        int z;
        z = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (!tbre) z++; end
        chk("tbre_low_cycles", 32'(z), 32'd1);
      end
    join
    check_frame(0, 8'h55, "f55");
    chk("f55_tsre_busy", 32'(cap_tsre[0]), 32'd0);
    chk("f55_tsre_159", 32'(cap_tsre[159]), 32'd0);
    chk("f55_tsre_160", 32'(cap_tsre[160]), 32'd1);

    // Back-to-back: 0xA3 queued behind 0x12, 0x7E refused while holding register full
    fork
      capture(400);
      begin
        write_byte(8'h12);
        write_byte(8'hA3);
        repeat (10) @(posedge clk);
        #1 chk("b2b_tbre_full", 32'(tbre), 32'd0);
        write_byte(8'h7E);
      end
    join
    check_frame(0, 8'h12, "b2b1");
    check_frame(160, 8'hA3, "b2b2");
    cnt = 0;
    for (int i = 0; i < 320; i++) if (cap_tsre[i]) cnt++;
    chk("b2b_tsre_low", 32'(cnt), 32'd0);
    chk("b2b_tsre_320", 32'(cap_tsre[320]), 32'd1);
    cnt = 0;
    for (int i = 320; i < 400; i++) if (!cap_txd[i]) cnt++;
    chk("b2b_no_third", 32'(cnt), 32'd0);

    for (int r = 0; r < 3; r++) begin
      rb = 8'($urandom);
      fork
        capture(170);
        write_byte(rb);
      join
      check_frame(0, rb, $sformatf("rtx%0d", r));
      chk($sformatf("rtx%0d_tsre", r), 32'(cap_tsre[160]), 32'd1);
    end

    // Directed RX table
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].glitch) send_glitch();
      else send_rx(tbl[i].data, tbl[i].stop, rise);
      if (i == 0) begin
        n_chk++;
        if (rise >= 152 && rise <= 158) n_pass++;
        else $display("FAIL rx_latency: got %0d cycles, want 152..158", rise);
      end
      chk($sformatf("rxv%0d_dr", i), 32'(data_ready), 32'(tbl[i].exp_dr));
      if (tbl[i].do_read) rd_check($sformatf("rxv%0d", i), tbl[i].exp_bus, tbl[i].exp_dr);
    end

    // Byte lands while rdn is held low: data_ready must survive the read
    fork
      send_rx(8'h4D, 1'b1, rise);
      begin
        repeat (140) @(posedge clk);
        #1 rdn = 1'b0;
        repeat (30) @(posedge clk);
        #1 rdn = 1'b1;
      end
    join
    chk("race_dr", 32'(data_ready), 32'd1);
    rd_check("race_read", 16'h004D, 1'b1);

    // Random RX against a last-valid-byte model
    exp_buf = 8'h4D;
    exp_dr  = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_rx(rb, rstop, rise);
      if (rstop) begin exp_buf = rb; exp_dr = 1'b1; end
      chk($sformatf("rrx%0d_dr", r), 32'(data_ready), 32'(exp_dr));
      if ($urandom_range(0, 1) == 1) begin
        rd_check($sformatf("rrx%0d", r), {8'h00, exp_buf}, exp_dr);
        exp_dr = 1'b0;
      end
    end

    // Reset in the middle of a TX frame with an unread byte pending
    send_rx(8'h6B, 1'b1, rise);
    chk("pre_rst_dr", 32'(data_ready), 32'd1);
    write_byte(8'h5B);
    repeat (60) @(negedge clk);
    chk("pre_rst_tsre", 32'(tsre), 32'd0);
    #2 rdn = 1'b0; rst = 1'b0;
    #1;
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_tbre", 32'(tbre), 32'd1);
    chk("mid_rst_tsre", 32'(tsre), 32'd1);
    chk("mid_rst_dr", 32'(data_ready), 32'd0);
    chk("mid_rst_bus_z", 32'(bus_data), 32'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b1; rdn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (txd !== 1'b1) cnt++; end
    chk("post_rst_no_frame", 32'(cnt), 32'd0);
    chk("post_rst_tsre", 32'(tsre), 32'd1);
    rd_check("post_rst", 16'h0000, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
